// File: rtl/riscv_mem_port_arbiter_if.sv
// Bundle of the three requester ports, the shared response and the downstream memory port.
interface riscv_mem_port_arbiter_if #(
    parameter int unsigned p_req_w   = 67,
    parameter int unsigned p_resp_w  = 35,
    parameter int unsigned p_max_out = 4
);
    localparam int unsigned cnt_w = $clog2(p_max_out) + 1;

    logic                req0_val;
    logic                req0_rdy;
    logic [p_req_w-1:0]  req0_msg;
    logic                req1_val;
    logic                req1_rdy;
    logic [p_req_w-1:0]  req1_msg;
    logic                req2_val;
    logic                req2_rdy;
    logic [p_req_w-1:0]  req2_msg;

    logic                resp0_val;
    logic                resp1_val;
    logic                resp2_val;
    logic [p_resp_w-1:0] resp_msg;

    logic                mem_req_val;
    logic                mem_req_rdy;
    logic [p_req_w-1:0]  mem_req_msg;
    logic                mem_resp_val;
    logic [p_resp_w-1:0] mem_resp_msg;

    logic [cnt_w-1:0]    outstanding;
    logic                err;

    // Core and memory side: drives requests and the memory handshake inputs
    modport master (
        output req0_val, req0_msg, req1_val, req1_msg, req2_val, req2_msg,
        output mem_req_rdy, mem_resp_val, mem_resp_msg,
        input  req0_rdy, req1_rdy, req2_rdy,
        input  resp0_val, resp1_val, resp2_val, resp_msg,
        input  mem_req_val, mem_req_msg, outstanding, err
    );

    // Arbiter side
    modport slave (
        input  req0_val, req0_msg, req1_val, req1_msg, req2_val, req2_msg,
        input  mem_req_rdy, mem_resp_val, mem_resp_msg,
        output req0_rdy, req1_rdy, req2_rdy,
        output resp0_val, resp1_val, resp2_val, resp_msg,
        output mem_req_val, mem_req_msg, outstanding, err
    );
endinterface

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one val/rdy memory port among imem0, imem1 and dmem; an in-order ID
// queue steers each memory response back to the requester that issued it.
module riscv_mem_port_arbiter #(
    parameter int unsigned p_req_w     = 67,
    parameter int unsigned p_resp_w    = 35,
    parameter int unsigned p_max_out   = 4,
    parameter bit          p_data_prio = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    riscv_mem_port_arbiter_if.slave     bus
);
    localparam int unsigned ptr_w = $clog2(p_max_out);
    localparam int unsigned cnt_w = $clog2(p_max_out) + 1;
    localparam logic [cnt_w-1:0] max_cnt = cnt_w'(p_max_out);

    logic [1:0]       id_q [p_max_out];
    logic [ptr_w-1:0] head_q, head_d;
    logic [ptr_w-1:0] tail_q, tail_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic             err_q, err_d;

    logic [2:0]       val_c;
    logic [2:0]       wins_c;
    logic [1:0]       ord_c [3];
    logic [1:0]       grant_c;
    logic             blocked_c;
    logic             full_c;
    logic             fire_c;
    logic             pop_c;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign val_c  = {bus.req2_val, bus.req1_val, bus.req0_val};
    assign full_c = (cnt_q == max_cnt);

    // Priority order for this cycle, highest first
    always_comb begin
        if (p_data_prio) begin
            ord_c[0] = 2'd2;
            ord_c[1] = rr_q[0] ? 2'd1 : 2'd0;
            ord_c[2] = rr_q[0] ? 2'd0 : 2'd1;
        end else begin
            ord_c[0] = rr_q;
            ord_c[1] = inc3(rr_q);
            ord_c[2] = inc3(inc3(rr_q));
        end
    end

    // A port "wins" when nothing ahead of it is valid, so its rdy never looks
    // at its own val; the grant is the first valid port in the order.
    always_comb begin
        blocked_c = 1'b0;
        wins_c    = '0;
        grant_c   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            wins_c[ord_c[k]] = !blocked_c;
            if (val_c[ord_c[k]] && !blocked_c) begin
                grant_c = ord_c[k];
            end
            if (val_c[ord_c[k]]) begin
                blocked_c = 1'b1;
            end
        end
    end

    // Full blocks issue even when a pop lands in the same cycle, keeping
    // mem_resp_val off the mem_req_val path.
    assign bus.mem_req_val = reset && (|val_c) && !full_c;
    assign fire_c          = bus.mem_req_val && bus.mem_req_rdy;
    assign bus.req0_rdy    = reset && wins_c[0] && bus.mem_req_rdy && !full_c;
    assign bus.req1_rdy    = reset && wins_c[1] && bus.mem_req_rdy && !full_c;
    assign bus.req2_rdy    = reset && wins_c[2] && bus.mem_req_rdy && !full_c;

    // Granted request passes straight through
    always_comb begin
        case (grant_c)
            2'd1:    bus.mem_req_msg = bus.req1_msg;
            2'd2:    bus.mem_req_msg = bus.req2_msg;
            default: bus.mem_req_msg = bus.req0_msg;
        endcase
    end

    // Responses go to the requester at the head of the ID queue
    assign pop_c         = reset && bus.mem_resp_val && (cnt_q != '0);
    assign bus.resp0_val = pop_c && (id_q[head_q] == 2'd0);
    assign bus.resp1_val = pop_c && (id_q[head_q] == 2'd1);
    assign bus.resp2_val = pop_c && (id_q[head_q] == 2'd2);
    assign bus.resp_msg  = bus.mem_resp_msg;

    assign bus.outstanding = cnt_q;
    assign bus.err         = err_q;

    // Next state for queue pointers, occupancy, RR pointer and error flag
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        rr_d   = rr_q;
        err_d  = err_q;
        cnt_d  = cnt_q + cnt_w'(fire_c) - cnt_w'(pop_c);
        if (fire_c) begin
            tail_d = tail_q + ptr_w'(1);
            if (!p_data_prio) begin
                rr_d = inc3(grant_c);
            end else if (grant_c != 2'd2) begin
                rr_d = (grant_c == 2'd0) ? 2'd1 : 2'd0;
            end
        end
        if (pop_c) begin
            head_d = head_q + ptr_w'(1);
        end
        if (bus.mem_resp_val && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Control state, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            rr_q   <= 2'd0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            err_q  <= err_d;
        end
    end

    // ID storage; stale entries are never read because occupancy gates the pop
    always_ff @(posedge clk) begin
        if (reset && fire_c) begin
            id_q[tail_q] <= grant_c;
        end
    end
endmodule
